// File: rtl/mem_req_seq.sv
// mem_req_seq: initiator-side sequencer for the single-ported simulation word
// memory. It accepts one read or write request at a time over a valid/ready
// handshake. It drives the memory pins from registers only and returns one
// response per request.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (req_ready = idle)
//   req_write            1 = write, 0 = read
//   req_addr             word address
//   req_data             write data
//   req_be               write byte-lane enables (lane 0 = MSB lane)
//   rsp_valid/rsp_ready  response handshake
//   rsp_data             read data (0 for writes and errors)
//   rsp_write            response belongs to a write
//   rsp_err              address was out of range
//   mem_addr             memory address
//   mem_din              memory write data
//   mem_dout             memory read data
//   mem_oe               memory output enable
//   mem_wea              memory byte-lane write enables
module mem_req_seq #(
  parameter int SIZE        = 1024,
  parameter int WIDTH       = 36,
  parameter int NBYTES      = 4,
  parameter int WAIT_CYCLES = 0,
  parameter int AW          = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [0:AW-1]     req_addr,
  input  logic [0:WIDTH-1]  req_data,
  input  logic [0:NBYTES-1] req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [0:WIDTH-1]  rsp_data,
  output logic              rsp_write,
  output logic              rsp_err,
  output logic [0:AW-1]     mem_addr,
  output logic [0:WIDTH-1]  mem_din,
  input  logic [0:WIDTH-1]  mem_dout,
  output logic              mem_oe,
  output logic [0:NBYTES-1] mem_wea
);

  typedef enum logic [1:0] {IDLE, RWAIT, WR, RSP} state_e;

  // One extra bit so SIZE itself is representable when SIZE is a power of two.
  localparam logic [AW:0] SIZE_W    = (AW+1)'(SIZE);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [0:WIDTH-1]    rsp_data_q, rsp_data_d;
  logic                rsp_write_q, rsp_write_d;
  logic                rsp_err_q, rsp_err_d;
  logic [0:AW-1]       mem_addr_q, mem_addr_d;
  logic [0:WIDTH-1]    mem_din_q, mem_din_d;
  logic                mem_oe_q, mem_oe_d;
  logic [0:NBYTES-1]   mem_wea_q, mem_wea_d;
  logic                addr_err;

  assign addr_err = ({1'b0, req_addr} >= SIZE_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_data_q  <= '0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_oe_q    <= 1'b0;
      mem_wea_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_oe_q    <= mem_oe_d;
      mem_wea_q   <= mem_wea_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_write_d = rsp_write_q;
    rsp_err_d   = rsp_err_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_oe_d    = mem_oe_q;
    mem_wea_d   = mem_wea_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rsp_write_d = req_write;
          rsp_err_d   = addr_err;
          rsp_data_d  = '0;
          if (addr_err) begin
            // Out of range: answer directly, memory pins untouched.
            state_d = RSP;
          end else if (req_write) begin
            mem_addr_d = req_addr;
            mem_din_d  = req_data;
            mem_wea_d  = req_be;
            state_d    = WR;
          end else begin
            mem_addr_d = req_addr;
            mem_oe_d   = 1'b1;
            cnt_d      = WAIT_INIT;
            state_d    = RWAIT;
          end
        end
      end
      RWAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_data_d = mem_dout;
          mem_oe_d   = 1'b0;
          state_d    = RSP;
        end
      end
      WR: begin
        // The memory commits on the edge leaving WR; enables last one cycle.
        mem_wea_d = '0;
        state_d   = RSP;
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RSP);
  assign rsp_data  = rsp_data_q;
  assign rsp_write = rsp_write_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_oe    = mem_oe_q;
  assign mem_wea   = mem_wea_q;

endmodule

// File: tb/tb_mem_req_seq.sv
// Bench for mem_req_seq. Two instances share the request inputs and are
// selected by 'sel': u0 has SIZE=1000, WAIT_CYCLES=0 and u1 has SIZE=1024,
// WAIT_CYCLES=3. Each instance has its own byte-lane word memory. Latencies
// are counted in clock edges with the accept edge counted as edge 1.
module tb_mem_req_seq;

  localparam int W  = 36;
  localparam int NB = 4;
  localparam int AW = 10;

  logic clk, rst_n, sel;
  logic req_valid, req_write, rsp_ready;
  logic [0:AW-1] req_addr;
  logic [0:W-1]  req_data;
  logic [0:NB-1] req_be;

  logic rr0, rr1, rv0, rv1, rw0, rw1, re0, re1, oe0, oe1;
  logic [0:W-1]  rd0, rd1, din0, din1, dout0, dout1;
  logic [0:AW-1] addr0, addr1;
  logic [0:NB-1] wea0, wea1;

  logic req_ready, rsp_valid, rsp_write, rsp_err, mem_oe;
  logic [0:W-1]  rsp_data, mem_din;
  logic [0:AW-1] mem_addr;
  logic [0:NB-1] mem_wea;

  int n_chk = 0;
  int n_fail = 0;

  mem_req_seq #(.SIZE(1000), .WIDTH(W), .NBYTES(NB), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(rr0),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
    .rsp_valid(rv0), .rsp_ready(rsp_ready & ~sel), .rsp_data(rd0), .rsp_write(rw0),
    .rsp_err(re0), .mem_addr(addr0), .mem_din(din0), .mem_dout(dout0),
    .mem_oe(oe0), .mem_wea(wea0));

  mem_req_seq #(.SIZE(1024), .WIDTH(W), .NBYTES(NB), .WAIT_CYCLES(3)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(rr1),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
    .rsp_valid(rv1), .rsp_ready(rsp_ready & sel), .rsp_data(rd1), .rsp_write(rw1),
    .rsp_err(re1), .mem_addr(addr1), .mem_din(din1), .mem_dout(dout1),
    .mem_oe(oe1), .mem_wea(wea1));

  assign req_ready = sel ? rr1 : rr0;
  assign rsp_valid = sel ? rv1 : rv0;
  assign rsp_data  = sel ? rd1 : rd0;
  assign rsp_write = sel ? rw1 : rw0;
  assign rsp_err   = sel ? re1 : re0;
  assign mem_oe    = sel ? oe1 : oe0;
  assign mem_wea   = sel ? wea1 : wea0;
  assign mem_addr  = sel ? addr1 : addr0;
  assign mem_din   = sel ? din1 : din0;

  // Word memories: byte lane k is bits k*9..k*9+8 (lane 0 = MSBs).
  logic [0:W-1] mem0 [0:1023];
  logic [0:W-1] mem1 [0:1023];
  assign dout0 = oe0 ? mem0[addr0] : '0;
  assign dout1 = oe1 ? mem1[addr1] : '0;
  always @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (wea0[k]) mem0[addr0][k*9 +: 9] <= din0[k*9 +: 9];
      if (wea1[k]) mem1[addr1][k*9 +: 9] <= din1[k*9 +: 9];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present a request and hold it until accepted; returns at accept edge + 1.
  task automatic send(input logic wr, input logic [0:AW-1] a, input logic [0:W-1] d,
                      input logic [0:NB-1] be);
    bit acc = 0;
    int n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_data = d; req_be = be;
    while (!acc && n < 50) begin
      @(negedge clk);
      if (req_ready) acc = 1;
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    n_chk++;
    if (!acc) begin n_fail++; $display("FAIL send_accept: not accepted after %0d cycles", n); end
  endtask

  // Called at accept edge + 1. Stops at the first sample showing rsp_valid.
  task automatic wait_rsp(output int edges, output int oe_n, output int wea_n,
                          output logic [0:NB-1] wea_v, output int rdy_n);
    edges = 1; oe_n = 0; wea_n = 0; wea_v = '0; rdy_n = 0;
    while (edges < 100) begin
      if (mem_oe) oe_n++;
      if (mem_wea != '0) begin wea_n++; wea_v = mem_wea; end
      if (req_ready) rdy_n++;
      if (rsp_valid) break;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b exp 1", req_ready); end
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b exp 0", rsp_valid); end
    n_chk++; if ({rsp_write, rsp_err, mem_oe} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b exp 000", {rsp_write, rsp_err, mem_oe}); end
    n_chk++; if (mem_wea !== 4'b0000) begin n_fail++; $display("FAIL rst_wea: got %b exp 0000", mem_wea); end
    n_chk++; if (rsp_data !== 36'd0 || mem_din !== 36'd0 || mem_addr !== 10'd0) begin
      n_fail++; $display("FAIL rst_data: rsp_data %o mem_din %o mem_addr %0d exp 0", rsp_data, mem_din, mem_addr); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release: ready %b valid %b exp 1 0", req_ready, rsp_valid); end
  endtask

  task automatic test_write_read();
    int e, o, wn, r; logic [0:NB-1] wv;
    sel = 1'b0; rsp_ready = 1'b1;
    send(1'b1, 10'd5, 36'o123456701234, 4'b1111);
    wait_rsp(e, o, wn, wv, r);
    n_chk++; if (e !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d exp 2", e); end
    n_chk++; if (wn !== 1 || wv !== 4'b1111) begin n_fail++; $display("FAIL wr_wea: cycles %0d val %b exp 1 1111", wn, wv); end
    n_chk++; if (rsp_write !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 36'd0) begin
      n_fail++; $display("FAIL wr_rsp: write %b err %b data %o exp 1 0 0", rsp_write, rsp_err, rsp_data); end
    take();
    n_chk++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_handshake: valid %b ready %b exp 0 1", rsp_valid, req_ready); end
    send(1'b0, 10'd5, 36'd0, 4'b0000);
    wait_rsp(e, o, wn, wv, r);
    n_chk++; if (e !== 2 || o !== 1) begin n_fail++; $display("FAIL rd_latency: edges %0d oe %0d exp 2 1", e, o); end
    n_chk++; if (rsp_data !== 36'o123456701234 || rsp_write !== 1'b0) begin
      n_fail++; $display("FAIL rd_data: got %o write %b exp 123456701234 0", rsp_data, rsp_write); end
    take();
  endtask

  task automatic test_byte_lanes();
    int e, o, wn, r; logic [0:NB-1] wv;
    sel = 1'b0; rsp_ready = 1'b1;
    send(1'b1, 10'd5, 36'o777777777777, 4'b0101);
    wait_rsp(e, o, wn, wv, r);
    n_chk++; if (wn !== 1 || wv !== 4'b0101) begin n_fail++; $display("FAIL be_wea: cycles %0d val %b exp 1 0101", wn, wv); end
    take();
    send(1'b0, 10'd5, 36'd0, 4'b0000);
    wait_rsp(e, o, wn, wv, r);
    n_chk++; if (rsp_data !== 36'o123777701777) begin n_fail++; $display("FAIL be_readback: got %o exp 123777701777", rsp_data); end
    take();
    // Zero enables: full write cycle, no lane changes, response still issued.
    send(1'b1, 10'd5, 36'd0, 4'b0000);
    wait_rsp(e, o, wn, wv, r);
    n_chk++; if (e !== 2 || wn !== 0 || rsp_write !== 1'b1) begin n_fail++; $display("FAIL be_zero: edges %0d wea %0d write %b exp 2 0 1", e, wn, rsp_write); end
    take();
    send(1'b0, 10'd5, 36'd0, 4'b0000);
    wait_rsp(e, o, wn, wv, r);
    n_chk++; if (rsp_data !== 36'o123777701777) begin n_fail++; $display("FAIL be_zero_readback: got %o exp 123777701777", rsp_data); end
    take();
  endtask

  task automatic test_wait_states();
    int e, o, wn, r; logic [0:NB-1] wv;
    bit ok;
    sel = 1'b1; rsp_ready = 1'b1;
    send(1'b1, 10'd5, 36'o123456701234, 4'b1111); wait_rsp(e, o, wn, wv, r); take();
    send(1'b1, 10'd6, 36'o000000000042, 4'b1111); wait_rsp(e, o, wn, wv, r); take();
    rsp_ready = 1'b0;
    send(1'b0, 10'd5, 36'd0, 4'b0000);
    // Second request held valid while the first is in flight.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd6;
    wait_rsp(e, o, wn, wv, r);
    n_chk++; if (e !== 5 || o !== 4) begin n_fail++; $display("FAIL ws_latency: edges %0d oe %0d exp 5 4", e, o); end
    n_chk++; if (r !== 0) begin n_fail++; $display("FAIL ws_ready_busy: ready seen %0d times exp 0", r); end
    n_chk++; if (rsp_data !== 36'o123456701234) begin n_fail++; $display("FAIL ws_data: got %o exp 123456701234", rsp_data); end
    ok = 1;
    repeat (3) begin @(posedge clk); #1; if (req_ready !== 1'b0 || rsp_valid !== 1'b1) ok = 0; end
    n_chk++; if (!ok) begin n_fail++; $display("FAIL ws_hold: second request not held off, ready %b valid %b", req_ready, rsp_valid); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL ws_handshake: valid %b ready %b exp 0 1", rsp_valid, req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_chk++; if (req_ready !== 1'b0 || mem_oe !== 1'b1 || mem_addr !== 10'd6) begin
      n_fail++; $display("FAIL ws_second_accept: ready %b oe %b addr %0d exp 0 1 6", req_ready, mem_oe, mem_addr); end
    wait_rsp(e, o, wn, wv, r);
    n_chk++; if (e !== 5 || rsp_data !== 36'o000000000042) begin n_fail++; $display("FAIL ws_second: edges %0d data %o exp 5 42", e, rsp_data); end
    take();
  endtask

  task automatic test_backpressure();
    int e, o, wn, r; logic [0:NB-1] wv;
    bit ok = 1;
    sel = 1'b0; rsp_ready = 1'b0;
    send(1'b0, 10'd5, 36'd0, 4'b0000);
    wait_rsp(e, o, wn, wv, r);
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== 36'o123777701777 || req_ready !== 1'b0) ok = 0;
    end
    n_chk++; if (!ok) begin n_fail++; $display("FAIL bp_stable: valid %b data %o exp 1 123777701777", rsp_valid, rsp_data); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: valid %b ready %b exp 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_addr_error();
    int e, o, wn, r; logic [0:NB-1] wv;
    sel = 1'b0; rsp_ready = 1'b1;
    send(1'b1, 10'd999, 36'o000000000777, 4'b1111); wait_rsp(e, o, wn, wv, r); take();
    send(1'b0, 10'd1000, 36'd0, 4'b0000);
    wait_rsp(e, o, wn, wv, r);
    n_chk++; if (e !== 1 || rsp_err !== 1'b1 || rsp_data !== 36'd0 || o !== 0) begin
      n_fail++; $display("FAIL err_read: edges %0d err %b data %o oe %0d exp 1 1 0 0", e, rsp_err, rsp_data, o); end
    take();
    send(1'b1, 10'd1000, 36'o777777777777, 4'b1111);
    wait_rsp(e, o, wn, wv, r);
    n_chk++; if (e !== 1 || rsp_err !== 1'b1 || rsp_data !== 36'd0 || wn !== 0) begin
      n_fail++; $display("FAIL err_write: edges %0d err %b data %o wea %0d exp 1 1 0 0", e, rsp_err, rsp_data, wn); end
    take();
    send(1'b0, 10'd999, 36'd0, 4'b0000);
    wait_rsp(e, o, wn, wv, r);
    n_chk++; if (rsp_data !== 36'o000000000777 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL err_readback: data %o err %b exp 777 0", rsp_data, rsp_err); end
    take();
  endtask

  task automatic test_reset_mid_write();
    int e, o, wn, r; logic [0:NB-1] wv;
    bit ok = 1;
    sel = 1'b0; rsp_ready = 1'b1;
    send(1'b1, 10'd7, 36'o111111111111, 4'b1111); wait_rsp(e, o, wn, wv, r); take();
    send(1'b1, 10'd7, 36'o222222222222, 4'b1111);
    n_chk++; if (mem_wea !== 4'b1111) begin n_fail++; $display("FAIL rmw_wea_on: got %b exp 1111", mem_wea); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (mem_wea !== 4'b0000 || mem_oe !== 1'b0) begin n_fail++; $display("FAIL rmw_async_drop: wea %b oe %b exp 0000 0", mem_wea, mem_oe); end
    repeat (3) begin @(posedge clk); #1; if (rsp_valid !== 1'b0) ok = 0; end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; if (rsp_valid !== 1'b0) ok = 0; end
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rmw_no_rsp: rsp_valid seen after reset"); end
    n_chk++; if (req_ready !== 1'b1 || {rsp_write, rsp_err, mem_oe} !== 3'b000 || mem_wea !== 4'b0000 ||
                 rsp_data !== 36'd0 || mem_addr !== 10'd0 || mem_din !== 36'd0) begin
      n_fail++; $display("FAIL rmw_reset_vals: ready %b w/e/oe %b wea %b data %o addr %0d din %o exp 1 000 0000 0 0 0",
                         req_ready, {rsp_write, rsp_err, mem_oe}, mem_wea, rsp_data, mem_addr, mem_din); end
    send(1'b0, 10'd7, 36'd0, 4'b0000);
    wait_rsp(e, o, wn, wv, r);
    n_chk++; if (rsp_data !== 36'o111111111111) begin n_fail++; $display("FAIL rmw_no_partial_write: got %o exp 111111111111", rsp_data); end
    take();
  endtask

  initial begin
    sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_data = '0; req_be = '0; rsp_ready = 1'b0; rst_n = 1'b0;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_wait_states();
    test_backpressure();
    test_addr_error();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
